// File: rtl/flow_sfifo.sv
// Synchronous valid/ready FIFO with registered occupancy count.
// full/empty come from the count register, so receive_ready never depends on send_ready.
module flow_sfifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             receive_valid,
  input  logic [WIDTH-1:0] receive_data,
  output logic             receive_ready,
  output logic             send_valid,
  output logic [WIDTH-1:0] send_data,
  input  logic             send_ready,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic             push, pop;

  assign full          = (count_q == CW'(DEPTH));
  assign empty         = (count_q == '0);
  assign count         = count_q;
  assign receive_ready = !full && !reset;
  assign send_valid    = !empty;
  assign send_data     = mem[rd_ptr];

  // reset is folded into receive_ready; pop gating covers the send side
  assign push = receive_valid && receive_ready;
  assign pop  = send_valid && send_ready && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // storage is intentionally not reset
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= receive_data;
  end

endmodule

// File: tb/tb_flow_sfifo.sv
// Self-checking bench for flow_sfifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_flow_sfifo;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             receive_valid = 1'b0;
  logic [WIDTH-1:0] receive_data = '0;
  logic             receive_ready;
  logic             send_valid;
  logic [WIDTH-1:0] send_data;
  logic             send_ready = 1'b0;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;

  int pass_cnt = 0;
  int total    = 0;

  logic [WIDTH-1:0] mq[$];

  flow_sfifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .receive_valid(receive_valid), .receive_data(receive_data), .receive_ready(receive_ready),
    .send_valid(send_valid), .send_data(send_data), .send_ready(send_ready),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clock = ~clock;

  // Advance one edge and apply the FIFO rules to the model, then settle.
  task automatic tick();
    bit do_push, do_pop;
    @(posedge clock);
    if (reset) mq.delete();
    else begin
      do_push = receive_valid && (mq.size() < DEPTH);
      do_pop  = send_ready && (mq.size() > 0);
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(receive_data);
    end
    #1;
  endtask

  task automatic idle();
    receive_valid = 0; send_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle();
    tick(); tick();
    total++; if (receive_ready !== 1'b0) $display("FAIL reset_rdy_during got %b exp 0", receive_ready); else pass_cnt++;
    reset = 0; #1;
    total++; if (count !== 0) $display("FAIL reset_count got %0d exp 0", count); else pass_cnt++;
    total++; if ({empty, full, send_valid} !== 3'b100) $display("FAIL reset_flags got %b exp 100", {empty, full, send_valid}); else pass_cnt++;
    total++; if (receive_ready !== 1'b1) $display("FAIL reset_rdy_after got %b exp 1", receive_ready); else pass_cnt++;
  endtask

  task automatic test_fill();
    send_ready = 0;
    for (int i = 1; i <= DEPTH; i++) begin
      receive_valid = 1; receive_data = WIDTH'(i);
      tick();
      total++; if (count !== CW'(i)) $display("FAIL fill_count got %0d exp %0d", count, i); else pass_cnt++;
    end
    total++; if ({full, receive_ready} !== 2'b10) $display("FAIL fill_full got %b exp 10", {full, receive_ready}); else pass_cnt++;
    receive_data = 16'h0005;
    tick();
    total++; if (count !== CW'(DEPTH)) $display("FAIL fill_reject got %0d exp %0d", count, DEPTH); else pass_cnt++;
    total++; if (send_data !== 16'h0001) $display("FAIL fill_head got %h exp 0001", send_data); else pass_cnt++;
  endtask

  task automatic test_drain();
    receive_valid = 0; send_ready = 1;
    for (int i = 1; i <= DEPTH; i++) begin
      total++; if ({send_valid, send_data} !== {1'b1, WIDTH'(i)}) $display("FAIL drain_word got %b/%h exp 1/%h", send_valid, send_data, WIDTH'(i)); else pass_cnt++;
      tick();
    end
    total++; if ({empty, send_valid} !== 2'b10) $display("FAIL drain_empty got %b exp 10", {empty, send_valid}); else pass_cnt++;
    send_ready = 0; receive_valid = 1; receive_data = 16'h0005;
    tick();
    receive_valid = 0;
    total++; if ({send_valid, send_data, count} !== {1'b1, 16'h0005, CW'(1)}) $display("FAIL drain_late got %b/%h/%0d exp 1/0005/1", send_valid, send_data, count); else pass_cnt++;
    send_ready = 1; tick(); send_ready = 0;
  endtask

  task automatic test_stream();
    receive_valid = 1; send_ready = 0;
    receive_data = 16'h0100; tick();
    receive_data = 16'h0101; tick();
    send_ready = 1;
    for (int k = 0; k < 10; k++) begin
      receive_data = WIDTH'(16'h0102 + k);
      total++; if (send_data !== WIDTH'(16'h0100 + k)) $display("FAIL stream_data got %h exp %h", send_data, WIDTH'(16'h0100 + k)); else pass_cnt++;
      tick();
      total++; if (count !== CW'(2)) $display("FAIL stream_count got %0d exp 2", count); else pass_cnt++;
    end
    receive_valid = 0; tick(); tick(); send_ready = 0;
    total++; if (empty !== 1'b1) $display("FAIL stream_drained got %b exp 1", empty); else pass_cnt++;
  endtask

  task automatic test_full_pop();
    send_ready = 0; receive_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin receive_data = WIDTH'($urandom); tick(); end
    receive_data = 16'hFFFF; send_ready = 1;
    tick();
    receive_valid = 0; send_ready = 0;
    total++; if (count !== CW'(DEPTH - 1)) $display("FAIL fullpop_count got %0d exp %0d", count, DEPTH - 1); else pass_cnt++;
    total++; if (receive_ready !== 1'b1) $display("FAIL fullpop_rdy got %b exp 1", receive_ready); else pass_cnt++;
    send_ready = 1;
    while (mq.size() > 0) begin
      total++; if (send_data !== mq[0]) $display("FAIL fullpop_data got %h exp %h", send_data, mq[0]); else pass_cnt++;
      tick();
    end
    send_ready = 0;
  endtask

  task automatic test_backpressure();
    receive_valid = 1; receive_data = 16'hBEEF; tick(); receive_valid = 0;
    for (int i = 0; i < 5; i++) begin
      total++; if ({send_valid, send_data} !== {1'b1, 16'hBEEF}) $display("FAIL stall_hold got %b/%h exp 1/beef", send_valid, send_data); else pass_cnt++;
      tick();
    end
    send_ready = 1;
    total++; if (send_data !== 16'hBEEF) $display("FAIL stall_release got %h exp beef", send_data); else pass_cnt++;
    tick(); send_ready = 0;
    total++; if (empty !== 1'b1) $display("FAIL stall_popped got %b exp 1", empty); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    receive_valid = 1;
    for (int i = 0; i < 3; i++) begin receive_data = WIDTH'(16'h0300 + i); tick(); end
    reset = 1; send_ready = 1; receive_data = 16'h0DDD; #1;
    total++; if (receive_ready !== 1'b0) $display("FAIL rstmid_rdy got %b exp 0", receive_ready); else pass_cnt++;
    tick();
    reset = 0; receive_valid = 0; send_ready = 0; #1;
    total++; if ({count, empty, send_valid, receive_ready} !== {CW'(0), 3'b101}) $display("FAIL rstmid_state got %0d/%b%b%b exp 0/101", count, empty, send_valid, receive_ready); else pass_cnt++;
    receive_valid = 1; receive_data = 16'hA5A5; tick();
    receive_data = 16'h1234; tick(); receive_valid = 0;
    total++; if (send_data !== 16'hA5A5) $display("FAIL rstmid_first got %h exp a5a5", send_data); else pass_cnt++;
    send_ready = 1; tick(); tick(); send_ready = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset         = ($urandom_range(0, 49) == 0);
      receive_valid = $urandom_range(0, 2) != 0;
      send_ready    = $urandom_range(0, 2) != 0;
      receive_data  = WIDTH'($urandom);
      #1;
      total++; if (receive_ready !== (!reset && mq.size() < DEPTH)) $display("FAIL rand_rdy got %b size %0d rst %b", receive_ready, mq.size(), reset); else pass_cnt++;
      total++; if ({count, full, empty, send_valid} !== {CW'(mq.size()), mq.size() == DEPTH, mq.size() == 0, mq.size() != 0})
        $display("FAIL rand_state got %0d/%b%b%b exp size %0d", count, full, empty, send_valid, mq.size()); else pass_cnt++;
      if (mq.size() > 0) begin
        total++; if (send_data !== mq[0]) $display("FAIL rand_data got %h exp %h", send_data, mq[0]); else pass_cnt++;
      end
      tick();
    end
    reset = 0; idle();
    reset = 1; tick(); reset = 0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_full_pop();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/flow_sfifo.md
# flow_sfifo

Parametrised synchronous FIFO carrying the valid/data flow protocol, extended with a ready back-pressure signal on both sides. It generalises the single registered flow stage into a buffer of configurable width and depth, with occupancy reporting. It sits between any flow producer and consumer in the same clock domain to absorb bursts and decouple stalls.

## Interface
- WIDTH, 16, data bits per word; ≥1.
- DEPTH, 4, words of storage; power of two, ≥2.
- CW, $clog2(DEPTH+1), width of count; derived, not to be overridden.

- clock  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high; clears all state at the clock edge where it is sampled high.
- receive_valid  input  1  producer offers receive_data.
- receive_data  input  WIDTH  word offered.
- receive_ready  output  1  FIFO accepts a word this cycle.
- send_valid  output  1  send_data holds the oldest stored word.
- send_data  output  WIDTH  oldest stored word.
- send_ready  input  1  consumer takes send_data this cycle.
- count  output  CW  words currently stored, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

## Operation
- Push: receive_valid && receive_ready at a rising edge; the word is written at wr_ptr, and wr_ptr advances.
- Pop: send_valid && send_ready at a rising edge; rd_ptr advances.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. full and empty come from a registered count, not from pointer comparison.
- receive_ready = !full && !reset. It never depends on send_ready, so there is no combinational path from send side to receive side.
- send_valid = !empty.
- send_data = mem[rd_ptr], read from storage registers with no input bypass.
- count update per edge:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push+pop, or on neither.
- Push+pop in the same cycle:
  - Allowed at any count 1..DEPTH-1: both pointers advance and count is unchanged.
  - At count == DEPTH, only the pop occurs (ready is low), so count becomes DEPTH-1.
  - At count == 0, only the push occurs (send_valid is low), so count becomes 1.
- receive_valid with receive_ready low: no effect. The producer must hold its word.
- send_ready with send_valid low: no effect.
- Storage array is not reset; its contents are don't-care until written.

## Timing
- Reset values, in effect from the edge after reset is sampled high:
  - count = 0, empty = 1, full = 0.
  - send_valid = 0, wr_ptr = rd_ptr = 0.
  - send_data = don't-care.
- receive_ready is 0 throughout any cycle in which reset is high, and 1 in the first cycle after reset deasserts.
- Reset mid-operation: all stored words are discarded. Handshakes in the reset cycle are ignored on both sides.
- Latency: a word pushed at edge N appears on send_data with send_valid = 1 in the cycle after edge N (one cycle when the FIFO was empty).
- Throughput: one push and one pop per cycle sustained, for any count 1..DEPTH-1.
- Stall stability: while send_valid && !send_ready, send_data and send_valid hold stable until a pop or a reset.
- full and receive_ready reflect the registered count:
  - After the push that fills the FIFO, receive_ready is 0 from the next cycle.
  - After a pop from full, receive_ready is 1 from the next cycle.

## Test plan
- Fill with DEPTH=4, WIDTH=16, send_ready=0:
  - Push 0x0001..0x0004 on consecutive cycles; count steps 1,2,3,4.
  - full=1 and receive_ready=0 after the 4th push.
  - A 5th word 0x0005 held on receive_valid is not accepted; count stays 4.
- Drain with send_ready=1:
  - Words emerge in order 0x0001..0x0004, one per cycle.
  - empty=1 and send_valid=0 after the last pop.
  - 0x0005 is then accepted, and appears on send_data the following cycle.
- Streaming at count 2:
  - Assert push and pop every cycle for 10 cycles with an incrementing pattern.
  - count stays 2; output equals input delayed by 2 words; both pointers wrap at least twice.
- Full plus pop: at count 4, assert receive_valid and send_ready together.
  - Only the pop occurs; count becomes 3; receive_ready=1 the next cycle.
- Back-pressure stability:
  - With 0xBEEF at the head and send_ready=0 for 5 cycles, send_data=0xBEEF and send_valid=1 hold every cycle.
  - Popped on the cycle send_ready rises.
- Reset mid-operation: with count 3, assert reset for 1 cycle.
  - receive_ready=0 during the reset cycle.
  - Next cycle: count=0, empty=1, send_valid=0, receive_ready=1.
  - The next word pushed is the first word out.
